// File: rtl/p08_muldiv_pkg.sv
// Shared types and constants for the 4-bit multiply/divide unit and its scheduler.
package p08_muldiv_pkg;
  localparam int MD_WIDTH  = 4;
  localparam int MD_DWIDTH = 8;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } md_state_t;

  typedef struct packed {
    logic [MD_WIDTH-1:0] a;
    logic [MD_WIDTH-1:0] b;
    logic                sgn;
    logic                op;
  } md_req_t;

  typedef struct packed {
    logic [MD_DWIDTH-1:0] data;
    logic                 eover;
    logic                 ediv0;
  } md_rsp_t;
endpackage

// File: rtl/p08_div4.sv
// 4-bit divider, truncating toward zero; remainder takes the dividend's sign.
module p08_div4
  import p08_muldiv_pkg::*;
(
  input  logic [MD_WIDTH-1:0] a,
  input  logic [MD_WIDTH-1:0] b,
  input  logic                sgn,
  output logic [MD_WIDTH-1:0] q,
  output logic [MD_WIDTH-1:0] r,
  output logic                eover,
  output logic                ediv0
);
  logic [MD_WIDTH-1:0] ma, mb, uq, ur;
  logic                na, nb;

  always_comb begin
    na    = sgn & a[MD_WIDTH-1];
    nb    = sgn & b[MD_WIDTH-1];
    ma    = na ? -a : a;
    mb    = nb ? -b : b;
    ediv0 = (b == '0);
    // -8 / -1 = +8 does not fit; the quotient wraps back to -8
    eover = sgn & (a == 4'h8) & (b == 4'hF);
    uq    = '0;
    ur    = '0;
    if (!ediv0) begin
      uq = ma / mb;
      ur = ma % mb;
    end
    q = (na ^ nb) ? -uq : uq;
    r = na ? -ur : ur;
  end
endmodule

// File: rtl/p08_mul4.sv
// 4x4 multiplier; signed mode sign-extends both operands, low 8 bits are exact.
module p08_mul4
  import p08_muldiv_pkg::*;
(
  input  logic [MD_WIDTH-1:0]  a,
  input  logic [MD_WIDTH-1:0]  b,
  input  logic                 sgn,
  output logic [MD_DWIDTH-1:0] p
);
  logic [MD_DWIDTH-1:0] ea, eb;

  assign ea = {{MD_WIDTH{sgn & a[MD_WIDTH-1]}}, a};
  assign eb = {{MD_WIDTH{sgn & b[MD_WIDTH-1]}}, b};
  assign p  = ea * eb;
endmodule

// File: rtl/p08_rr_arb.sv
// Round-robin arbiter: search starts at ptr and wraps; grant is gated by en.
module p08_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic [IDW-1:0]  nxt_ptr
);
  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = en;
        gnt_id      = idx[IDW-1:0];
      end
    end
  end

  assign nxt_ptr = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
endmodule

// File: rtl/p08_muldiv4_sched.sv
// Round-robin scheduler in front of the shared mul4/div4 datapath; one op in flight,
// tagged response with backpressure.
module p08_muldiv4_sched
  import p08_muldiv_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [4*NREQ-1:0]      req_a,
  input  logic [4*NREQ-1:0]      req_b,
  input  logic [NREQ-1:0]        req_signed,
  input  logic [NREQ-1:0]        req_div,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [MD_DWIDTH-1:0]   rsp_data,
  output logic                   rsp_eover,
  output logic                   rsp_ediv0,
  output logic                   busy,
  output logic [7:0]             done_cnt
);
  md_state_t            state, state_nxt;
  md_req_t              op_q;
  md_rsp_t              res;
  logic [IDW-1:0]       id_q, ptr, gnt_id, nxt_ptr;
  logic [NREQ-1:0]      gnt;
  logic                 accept;
  logic [MD_DWIDTH-1:0] prod;
  logic [MD_WIDTH-1:0]  quo, rem;
  logic                 d_eover, d_ediv0;

  p08_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid), .ptr(ptr), .en(state == IDLE),
    .gnt(gnt), .gnt_id(gnt_id), .nxt_ptr(nxt_ptr)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);
  assign busy      = (state != IDLE);

  p08_mul4 u_mul (.a(op_q.a), .b(op_q.b), .sgn(op_q.sgn), .p(prod));
  p08_div4 u_div (.a(op_q.a), .b(op_q.b), .sgn(op_q.sgn),
                  .q(quo), .r(rem), .eover(d_eover), .ediv0(d_ediv0));

  always_comb begin
    if (op_q.op == OP_DIV) res = '{data: {rem, quo}, eover: d_eover, ediv0: d_ediv0};
    else                   res = '{data: prod, eover: 1'b0, ediv0: 1'b0};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      id_q      <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_eover <= 1'b0;
      rsp_ediv0 <= 1'b0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= '{a:   req_a[{gnt_id, 2'b00} +: MD_WIDTH],
                    b:   req_b[{gnt_id, 2'b00} +: MD_WIDTH],
                    sgn: req_signed[gnt_id],
                    op:  req_div[gnt_id]};
          id_q <= gnt_id;
          ptr  <= nxt_ptr;
        end
        EXEC: begin
          rsp_data  <= res.data;
          rsp_eover <= res.eover;
          rsp_ediv0 <= res.ediv0;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          done_cnt  <= done_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
